// File: rtl/phy_rx_deser.sv
// phy_rx_deser: receive deserializer for the PHY serial link.
// Hunts for IDLE_WORD to find word boundaries, locks after SYNC_COUNT consecutive
// aligned idles, then presents each non-idle 32-bit word on data_out/valid_out.
// Optional: define PHY_RX_WORDCNT_EN to add a saturating received-word counter.
module phy_rx_deser #(
  parameter int unsigned          DATA_W     = 32,
  parameter logic [DATA_W-1:0]    IDLE_WORD  = 32'hBCBCBCBC,
  parameter int unsigned          SYNC_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_serial,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
`ifdef PHY_RX_WORDCNT_EN
  ,
  output logic [15:0]       word_count
`endif
);

  localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned IdleW = $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {StSearch, StLocking, StActive} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] nxt;
  logic              is_idle;
  logic              boundary;
  logic [IdleW-1:0]  idle_cnt_inc;

`ifdef PHY_RX_WORDCNT_EN
  logic [15:0] wc_q, wc_d;
  assign word_count = wc_q;
`endif

  // Word including the bit being sampled this edge; all decisions look at this.
  assign nxt          = {sr_q[DATA_W-2:0], data_serial};
  assign is_idle      = (nxt == IDLE_WORD);
  assign boundary     = (bit_cnt_q == CntW'(DATA_W - 1));
  assign idle_cnt_inc = idle_cnt_q + IdleW'(1);

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = (state_q == StActive);

  // State registers; shift register runs on every edge regardless of state.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= StSearch;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
`ifdef PHY_RX_WORDCNT_EN
      wc_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      sr_q       <= nxt;
      data_q     <= data_d;
      valid_q    <= valid_d;
`ifdef PHY_RX_WORDCNT_EN
      wc_q       <= wc_d;
`endif
    end
  end

  // Alignment FSM and output capture.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
`ifdef PHY_RX_WORDCNT_EN
    wc_d       = wc_q;
`endif
    unique case (state_q)
      StSearch: begin
        if (is_idle) begin
          // The matched idle ends a word, so the next bit starts a new one.
          bit_cnt_d = '0;
          if (SYNC_COUNT == 1) begin
            state_d = StActive;
          end else begin
            idle_cnt_d = IdleW'(1);
            state_d    = StLocking;
          end
        end
      end
      StLocking: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + CntW'(1);
        if (boundary) begin
          if (is_idle) begin
            idle_cnt_d = idle_cnt_inc;
            if (idle_cnt_inc == IdleW'(SYNC_COUNT)) begin
              state_d = StActive;
            end
          end else begin
            idle_cnt_d = '0;
            state_d    = StSearch;
          end
        end
      end
      StActive: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + CntW'(1);
        if (boundary) begin
          if (is_idle) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
`ifdef PHY_RX_WORDCNT_EN
            if (wc_q != 16'hFFFF) begin
              wc_d = wc_q + 16'd1;
            end
`endif
          end
        end
      end
      default: begin
        state_d = StSearch;
      end
    endcase
  end

endmodule

// File: tb/tb_phy_rx_deser.sv
// Self-checking bench for phy_rx_deser: directed scenarios plus randomized streams,
// scored against a bit-history model through an expectation queue.
module tb_phy_rx_deser;

  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] IDLE   = 32'hBCBCBCBC;
  localparam int unsigned SYNC   = 4;

  logic        clk_32f = 1'b0;
  logic        reset = 1'b0;
  logic        data_serial = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
`ifdef PHY_RX_WORDCNT_EN
  logic [15:0] word_count;
`endif

  phy_rx_deser #(
    .DATA_W     (DATA_W),
    .IDLE_WORD  (IDLE),
    .SYNC_COUNT (SYNC)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_serial (data_serial),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active)
`ifdef PHY_RX_WORDCNT_EN
    ,
    .word_count  (word_count)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic        act;
    logic        vld;
    logic [31:0] dat;
    logic [15:0] wc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: last DATA_W received bits plus alignment bookkeeping.
  bit          hist[$];
  bit          m_aligned;
  bit          m_locked;
  bit          m_vld;
  int          m_since;
  int          m_idles;
  logic [31:0] m_dat;
  logic [15:0] m_wc;

  function automatic void model_reset();
    hist.delete();
    m_aligned = 1'b0;
    m_locked  = 1'b0;
    m_vld     = 1'b0;
    m_since   = 0;
    m_idles   = 0;
    m_dat     = '0;
    m_wc      = '0;
  endfunction

  function automatic void model_step(input bit b);
    logic [31:0] w;
    exp_t        e;
    hist.push_back(b);
    if (hist.size() > DATA_W) void'(hist.pop_front());
    w = '0;
    foreach (hist[i]) w = {w[30:0], hist[i]};
    if (!m_aligned) begin
      if (w == IDLE) begin
        m_aligned = 1'b1;
        m_since   = 0;
        m_idles   = 1;
        if (m_idles >= SYNC) m_locked = 1'b1;
      end
    end else begin
      m_since++;
      if (m_since == DATA_W) begin
        m_since = 0;
        if (!m_locked) begin
          if (w == IDLE) begin
            m_idles++;
            if (m_idles >= SYNC) m_locked = 1'b1;
          end else begin
            m_aligned = 1'b0;
            m_idles   = 0;
          end
        end else if (w == IDLE) begin
          m_vld = 1'b0;
        end else begin
          m_dat = w;
          m_vld = 1'b1;
          if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        end
      end
    end
    e = '{act: m_locked, vld: m_vld, dat: m_dat, wc: m_wc};
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: each sampled bit has one queued expectation for the edge that takes it in.
  always @(posedge clk_32f) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({active, valid_out, data_out} !== {e.act, e.vld, e.dat}) begin
        n_fail++;
        $display("FAIL outputs: got act=%b vld=%b dat=%h, expected act=%b vld=%b dat=%h at %0t",
                 active, valid_out, data_out, e.act, e.vld, e.dat, $time);
      end
`ifdef PHY_RX_WORDCNT_EN
      n_vec++;
      if (word_count !== e.wc) begin
        n_fail++;
        $display("FAIL word_count: got %0d, expected %0d at %0t", word_count, e.wc, $time);
      end
`endif
    end
  end

  // Stimulus tasks enter and leave at a falling edge.
  task automatic send_bit(input bit b);
    data_serial = b;
    model_step(b);
    @(negedge clk_32f);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk_32f);
    check("reset_state", {31'd0, active, valid_out, data_out}, 64'd0);
    reset = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 check("async_reset", {31'd0, active, valid_out, data_out}, 64'd0);
    model_reset();
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 check("power_on_reset", {31'd0, active, valid_out, data_out}, 64'd0);
    model_reset();
    @(negedge clk_32f);
    reset = 1'b0;

    // Idle line of zeros never locks.
    repeat (200) send_bit(1'b0);

    // Misaligned start, then lock on the fourth idle.
    repeat (7) send_bit(1'($urandom_range(0, 1)));
    repeat (4) send_word(IDLE);
    check("locked_after_4_idles", {63'd0, active}, 64'd1);

    // Back-to-back data then idles.
    send_word(32'hFFFFFFFF);
    send_word(32'hEEEEEEEE);
    send_word(32'hDDDDDDDD);
    send_word(32'hCCCCCCCC);
    send_word(IDLE);
    send_word(IDLE);
    check("hold_after_idle", {31'd0, active, valid_out, data_out}, {31'd0, 1'b1, 1'b0, 32'hCCCCCCCC});

    // Lock attempt broken by data returns to search.
    do_reset();
    send_word(IDLE);
    send_word(IDLE);
    send_word(32'h12345678);
    check("no_lock_after_break", {62'd0, active, valid_out}, 64'd0);
    repeat (4) send_word(IDLE);
    send_word(32'h11111111);

    // Asynchronous reset mid-word while locked with valid data.
    send_word(32'h5A5A1234);
    repeat (10) send_bit(1'($urandom_range(0, 1)));
    check("valid_before_reset", {63'd0, valid_out}, 64'd1);
    async_reset();
    repeat (4) send_word(IDLE);
    send_word(32'h0A0A0A0A);
    send_word(IDLE);

    // Randomized streams: random preamble, variable idle run, mixed traffic.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      repeat ($urandom_range(0, 40)) send_bit(1'($urandom_range(0, 1)));
      repeat ($urandom_range(2, 6)) send_word(IDLE);
      for (int k = 0; k < 24; k++) begin
        case ($urandom_range(0, 4))
          0:       send_word(IDLE);
          1:       send_word(32'hFFFFFFFF);
          default: send_word(32'($urandom));
        endcase
      end
      if (r % 2 == 1) begin
        repeat ($urandom_range(1, 31)) send_bit(1'($urandom_range(0, 1)));
        async_reset();
        repeat (4) send_word(IDLE);
        send_word(32'($urandom));
      end
    end

    // Every queued expectation must have been consumed.
    repeat (3) @(posedge clk_32f);
    #2 check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
